// File: rtl/fetch_group_rom_if.sv
// Fetch-to-decode bus: fetch control and redirect inputs, fetch-group outputs.
interface fetch_group_rom_if #(
  parameter int ISSUE_WIDTH = 2
);
  logic                   i_en;
  logic                   i_ready;
  logic                   i_redirect;
  logic [31:0]            i_redirect_pc;
  logic                   o_valid;
  logic [31:0]            o_insts [0:ISSUE_WIDTH-1];
  logic [ISSUE_WIDTH-1:0] o_lane_valid;
  logic [31:0]            o_pc;
  logic                   o_done;

  modport master (
    output i_en, i_ready, i_redirect, i_redirect_pc,
    input  o_valid, o_insts, o_lane_valid, o_pc, o_done
  );

  modport slave (
    input  i_en, i_ready, i_redirect, i_redirect_pc,
    output o_valid, o_insts, o_lane_valid, o_pc, o_done
  );
endinterface

// File: rtl/fetch_group_rom.sv
// Instruction ROM and fetch unit. Issues ISSUE_WIDTH sequential words per group, owns the fetch PC,
// and pads past the end of the program with NOP. The image is supplied through INIT_IMAGE.
module fetch_group_rom #(
  parameter int                     ISSUE_WIDTH = 2,
  parameter int                     DEPTH       = 1024,
  parameter int                     PROG_WORDS  = DEPTH,
  parameter logic [31:0]            NOP_WORD    = 32'h0000_0013,
  parameter logic [31:0]            RESET_PC    = 32'h0000_0000,
  parameter logic [DEPTH-1:0][31:0] INIT_IMAGE  = '0
) (
  input logic              i_clk,
  input logic              i_rst_n,
  fetch_group_rom_if.slave bus
);
  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit          WRAP     = (PROG_WORDS == DEPTH);
  localparam logic [32:0] PROG_W33 = 33'(PROG_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [31:0]            pc_q, pc_d;
  logic                   valid_q, valid_d;
  logic [31:0]            pc_out_q, pc_out_d;
  logic [31:0]            insts_q [0:ISSUE_WIDTH-1];
  logic [31:0]            insts_d [0:ISSUE_WIDTH-1];
  logic [ISSUE_WIDTH-1:0] lane_q, lane_d;
  logic                   done_q, done_d;

  logic [32:0]            idx_s [0:ISSUE_WIDTH-1];
  logic [31:0]            grp_insts_s [0:ISSUE_WIDTH-1];
  logic [ISSUE_WIDTH-1:0] grp_lane_s;
  logic                   last_hit_s;
  logic                   tgt_ok_s;
  logic                   load_s;
  logic [31:0]            redirect_pc_s;

  // Word indices wrap only when the whole ROM is program; otherwise out-of-range reads pad.
  function automatic logic [32:0] eff_index(input logic [32:0] raw);
    if (WRAP) begin
      eff_index = {{(33-AW){1'b0}}, raw[AW-1:0]};
    end else begin
      eff_index = raw;
    end
  endfunction

  // Group read at the current fetch PC
  always_comb begin
    grp_lane_s = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      idx_s[k]       = eff_index({3'b000, pc_q[31:2]} + 33'(k));
      grp_lane_s[k]  = (idx_s[k] < PROG_W33);
      grp_insts_s[k] = grp_lane_s[k] ? INIT_IMAGE[idx_s[k][AW-1:0]] : NOP_WORD;
    end
    last_hit_s    = (idx_s[ISSUE_WIDTH-1] >= (PROG_W33 - 33'd1));
    redirect_pc_s = bus.i_redirect_pc & 32'hFFFF_FFFC;
    tgt_ok_s      = (eff_index({3'b000, bus.i_redirect_pc[31:2]}) < PROG_W33);
    load_s        = (state_q == RUN) && bus.i_en && !bus.i_redirect && (!valid_q || bus.i_ready);
  end

  // FSM next state, PC and output-register next values; redirect outranks everything
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    pc_out_d = pc_out_q;
    insts_d  = insts_q;
    lane_d   = lane_q;
    case (state_q)
      IDLE: begin
        if (bus.i_redirect) begin
          pc_d = redirect_pc_s;
        end else if (bus.i_en) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (bus.i_redirect) begin
          pc_d    = redirect_pc_s;
          valid_d = 1'b0;
        end else if (load_s) begin
          insts_d  = grp_insts_s;
          lane_d   = grp_lane_s;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          pc_d     = pc_q + 32'(4 * ISSUE_WIDTH);
          if (last_hit_s) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end else if (valid_q && bus.i_ready) begin
          valid_d = 1'b0;
        end else begin
          valid_d = valid_q;
        end
      end
      DONE: begin
        if (bus.i_redirect) begin
          pc_d    = redirect_pc_s;
          valid_d = 1'b0;
          if (tgt_ok_s) begin
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end else if (valid_q && bus.i_ready) begin
          valid_d = 1'b0;
        end else begin
          valid_d = valid_q;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
    done_d = (state_d == DONE) && !valid_d;
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      pc_out_q <= 32'h0000_0000;
      insts_q  <= '{default: NOP_WORD};
      lane_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      pc_out_q <= pc_out_d;
      insts_q  <= insts_d;
      lane_q   <= lane_d;
      done_q   <= done_d;
    end
  end

  assign bus.o_valid      = valid_q;
  assign bus.o_insts      = insts_q;
  assign bus.o_lane_valid = lane_q;
  assign bus.o_pc         = pc_out_q;
  assign bus.o_done       = done_q;
endmodule
